// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Holds the scan FSM state type, the anode polarity and the default slot timing.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Board anodes are driven through PNP switches, so a low level lights a digit.
  localparam logic SEG_ACTIVE_LOW = 1'b1;
  localparam logic AN_ON  = SEG_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic AN_OFF = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam int DEF_DIGIT_CYCLES = 100000;
  localparam int DEF_BLANK_CYCLES = 1000;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_driver_tick_gen.sv
// Slot counter for the scan driver: counts 0..DIGIT_CYCLES-1 and flags the
// last blanking cycle and the last cycle of the slot.
module scan_tick_gen
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = idx_width(DIGIT_CYCLES);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_timing
    $error("scan_tick_gen: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign slot_done  = (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
  assign blank_done = (cnt_q == CNT_W'(BLANK_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (slot_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed digit scanner: double-buffers a packed nibble frame, walks
// the digits with a blanking gap per slot and drives active-low anode strobes.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int IDX_W        = idx_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    load_req,
  output logic                    load_ack,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_start
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_driver: NUM_DIGITS must be in 1..8");
  end

  logic blank_done;
  logic slot_done;

  scan_tick_gen #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  scan_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [3:0]              nib_q, nib_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;
  logic                    ack_q, ack_d;
  logic                    wrap;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   sel_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK: if (blank_done) state_d = DRIVE;
      DRIVE: if (slot_done)  state_d = BLANK;
    endcase
  end

  // The shadow frame only moves on the wrap edge, so a frame never tears.
  assign wrap    = slot_done && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign capture = wrap && load_req;

  always_comb begin
    idx_d = idx_q;
    if (slot_done) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    dig_d = capture ? digits_in   : dig_q;
    en_d  = capture ? digit_en_in : en_q;
    fs_d  = wrap;
    ack_d = capture;
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign sel_d[gi] = (idx_d == IDX_W'(gi));
  end

  // Outputs are computed from next-state values so they line up with the counter.
  always_comb begin
    nib_d = nib_q;
    an_d  = {NUM_DIGITS{AN_OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_done && sel_d[k]) begin
        nib_d = dig_d[4*k +: 4];
      end
      if (state_d == DRIVE && sel_d[k] && en_d[k]) begin
        an_d[k] = AN_ON;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      idx_q   <= '0;
      dig_q   <= '0;
      en_q    <= '0;
      nib_q   <= '0;
      an_q    <= {NUM_DIGITS{AN_OFF}};
      fs_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
      nib_q   <= nib_d;
      an_q    <= an_d;
      fs_q    <= fs_d;
      ack_q   <= ack_d;
    end
  end

  assign load_ack    = ack_q;
  assign nibble_out  = nib_q;
  assign an_n        = an_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 8-cycle slots, 2-cycle blank):
// per-cycle expectations are queued as stimulus is driven and popped after each edge.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int DC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * DC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  digit_en_in = '0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic [3:0]  nibble_out;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_start;

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .IDX_W       (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .digit_en_in(digit_en_in),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .nibble_out (nibble_out),
    .an_n       (an_n),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] nib;
    logic [1:0] idx;
    logic       fs;
    logic       ack;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          t = 0;
  int          ack_cnt = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_en = '0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s t=%0d: observed %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs at cycle nt of the scan timeline, counted from reset release.
  function automatic exp_t model(input int nt, input logic cap);
    int   slot;
    int   pos;
    exp_t e;
    slot  = (nt / DC) % ND;
    pos   = nt % DC;
    e.an  = (pos >= BC && m_en[slot]) ? ~(4'b0001 << slot) : 4'hF;
    e.nib = m_dig[4*slot +: 4];
    e.idx = 2'(slot);
    e.fs  = (nt % FRAME == 0) && (nt > 0);
    e.ack = cap;
    return e;
  endfunction

  task automatic step();
    int   nt;
    logic cap;
    exp_t e;
    nt  = t + 1;
    cap = load_req && (nt % FRAME == 0);
    if (cap) begin
      m_dig = digits_in;
      m_en  = digit_en_in;
    end
    sb.push_back(model(nt, cap));
    @(posedge clk);
    #1;
    t = nt;
    e = sb.pop_front();
    chk("an_n",        {4'b0, an_n},        {4'b0, e.an});
    chk("nibble_out",  {4'b0, nibble_out},  {4'b0, e.nib});
    chk("digit_idx",   {6'b0, digit_idx},   {6'b0, e.idx});
    chk("frame_start", {7'b0, frame_start}, {7'b0, e.fs});
    chk("load_ack",    {7'b0, load_ack},    {7'b0, e.ack});
    if (load_ack === 1'b1) ack_cnt++;
  endtask

  task automatic run_until(input int target);
    while (t < target) step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_an_n"},   {4'b0, an_n},        8'h0F);
    chk({tag, "_idx"},    {6'b0, digit_idx},   8'h00);
    chk({tag, "_nibble"}, {4'b0, nibble_out},  8'h00);
    chk({tag, "_fs"},     {7'b0, frame_start}, 8'h00);
    chk({tag, "_ack"},    {7'b0, load_ack},    8'h00);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("in_reset");
    rst_n = 1'b1;
    #1;
    t = 0;
    chk_idle("release");

    // Dark first frame, then capture 3A07 at the first wrap.
    run_until(24);
    digits_in = 16'h3A07; digit_en_in = 4'hF; load_req = 1'b1;
    run_until(32);
    load_req = 1'b0;

    // Mid-frame input change without a request must not show.
    run_until(40);
    digits_in = 16'hFFFF; digit_en_in = 4'h0;
    run_until(60);
    digits_in = 16'h5C2E; digit_en_in = 4'b1011; load_req = 1'b1;
    run_until(64);
    load_req = 1'b0;
    run_until(90);
    digits_in = 16'h1234; digit_en_in = 4'hF; load_req = 1'b1;
    run_until(96);
    load_req = 1'b0;

    // Asynchronous reset while digit 2 is being driven.
    run_until(116);
    chk("pre_reset_an_n", {4'b0, an_n}, 8'h0B);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    t = 0;
    m_dig = '0;
    m_en = '0;
    ack_cnt = 0;
    chk_idle("rerelease");

    // Request held across three wraps with fresh data each frame.
    digits_in = 16'h1111; digit_en_in = 4'hF;
    run_until(5);
    load_req = 1'b1;
    run_until(32);
    digits_in = 16'h2222;
    run_until(64);
    digits_in = 16'h3333;
    run_until(96);
    load_req = 1'b0;
    run_until(110);
    chk("ack_count", 8'(ack_cnt), 8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
